frame_step_master: RTL and testbench
====================================

# frame_step_master

Per-frame step scheduler that acts as the initiator side of the object step handshake (`req`/`ack`/`frame_term`/`cal_frame`) answered by the game's gadget and ball objects. On each frame start it broadcasts `o_cal_frame`, then grants single-step requests round-robin to every enabled object until each reports `frame_term`, and finally pulses `o_frame_done`. This serialisation lets collision logic between objects see consistent positions after every substep. It sits between the VGA frame timing and the object array.

## Interface
- `N_OBJ`, 4: number of object slots (2..16).
- `TIMEOUT_CYC`, 64: ack watchdog limit in cycles (used only with `FSM_TIMEOUT_EN`).
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-high.
- `i_frame_start`  in  1  one-cycle pulse per video frame.
- `i_obj_en`  in  N_OBJ  per-slot enable; sampled in CAL.
- `o_cal_frame`  out  1  one-cycle broadcast restarting the objects' step counters.
- `o_obj_req`  out  N_OBJ  one-hot step request (at most one bit set).
- `i_obj_ack`  in  N_OBJ  per-object acknowledge.
- `i_obj_frame_term`  in  N_OBJ  object has finished its steps for this frame.
- `o_busy`  out  1  high in every state except IDLE.
- `o_frame_done`  out  1  one-cycle pulse when the frame is complete.
- `o_round_cnt`  out  8  rounds completed in the current or last frame; saturates at 255.
- `o_overrun`  out  1  sticky flag: `i_frame_start` arrived while busy.
- `o_timeout_err`  out  1  sticky watchdog flag; tied 0 without `FSM_TIMEOUT_EN`.

## Operation
- States: IDLE, CAL, SETTLE, SCAN, REQ, GAP, DONE.
- **IDLE**
  - `i_frame_start` goes to CAL.
  - CAL clears `o_round_cnt`, sets `ptr=0`, latches `en_q = i_obj_en`, and asserts `o_cal_frame` for exactly one cycle.
- **SETTLE**: one cycle, so that objects drop `frame_term` before it is sampled. Then go to SCAN.
- **SCAN** (one cycle per slot)
  - If `en_q[ptr]` is 0 or `i_obj_frame_term[ptr]` is 1, skip the slot.
  - Otherwise go to REQ.
  - Skip or return from GAP advances the pointer:
    - If `ptr==N_OBJ-1`, wrap `ptr` to 0 and increment `o_round_cnt` (saturating).
    - Then, if every enabled slot has `frame_term` high, go to DONE; otherwise stay in SCAN.
- **REQ**
  - `o_obj_req[ptr]` is held high until the cycle where `o_obj_req[ptr] && i_obj_ack[ptr]` is true (the handshake).
  - `i_obj_ack` on other bits is ignored.
- **GAP**: req low for one cycle so the object can clear its registered ack. Then return to SCAN with the pointer advance described above.
- **DONE**: `o_frame_done` high for one cycle, then go to IDLE.
- **All disabled**: if `en_q` is all zero, the sequence is CAL → SETTLE → one full SCAN pass → DONE, with `o_round_cnt=1`.
- **Frame start while busy**: `i_frame_start` in any non-IDLE state is ignored and sets `o_overrun`. A start coincident with DONE also sets `o_overrun`.
- **Clearing flags**: `rst` is the only way to clear the sticky flags.

## Timing
- Reset values:
  - State IDLE, `ptr=0`, `en_q=0`.
  - All outputs 0, including `o_round_cnt`, `o_overrun` and `o_timeout_err`.
- All outputs are registered.
- `i_frame_start` at cycle t gives `o_cal_frame` at t+1 (CAL), SETTLE at t+2, first SCAN at t+3.
- Earliest req is visible at t+4. A handshake at cycle h gives req low at h+1 (GAP).
- **Cost per step**:
  - Each serviced step costs 3 cycles (SCAN, REQ with same-cycle ack, GAP).
  - Each skipped slot costs 1 cycle.
- `frame_term` of the object just stepped is sampled in SCAN, which is at least 2 cycles after its handshake.
- Reset asserted mid-frame returns to IDLE on the next edge with req dropped. Objects resynchronise on the next `o_cal_frame`.

## Configuration
- `FSM_TIMEOUT_EN` defined:
  - An 8-bit-minimum counter runs in REQ.
  - If no handshake occurs within `TIMEOUT_CYC` cycles, req drops, `en_q[ptr]` is cleared (the slot is treated as terminated for this frame), `o_timeout_err` is set, and the FSM proceeds to GAP.
- `FSM_TIMEOUT_EN` undefined:
  - No counter; REQ waits indefinitely.
  - `o_timeout_err` is constant 0.

## Structure
- Shared package holds:
  - state enum `fsm_state_t`;
  - `OBJ_GADGET`/`OBJ_BALL` slot index constants;
  - `ROUND_CNT_BITS=8`.
- One sub-module, `rr_slot_ptr`: pointer register with advance/wrap and a round-increment output.
- FSM, flags and watchdog live in the top module.

## Test plan
- **Single object, 3 substeps**: N_OBJ=4, `i_obj_en=4'b0001`, responder acks same cycle and asserts term after its 3rd ack.
  - Expect 3 handshakes, `o_round_cnt=3`, `o_frame_done` once.
  - Expect `o_obj_req[3:1]` always 0.
- **Two objects with unequal steps (5 and 2)**:
  - Req order must be 0,1,0,1,0,0,0.
  - Expect `o_round_cnt=5` and `o_frame_done` once.
- **All slots disabled**: `o_frame_done` exactly 7 cycles after `i_frame_start` (t+1…t+3, 4 SCAN cycles at t+3…t+6, DONE at t+7), with `o_round_cnt=1`.
- **Frame start while busy**: second `i_frame_start` mid-frame.
  - `o_overrun`=1 and stays 1.
  - Current frame completes normally and no second `o_cal_frame` is issued.
- **Watchdog**: object 2 never acks, with `FSM_TIMEOUT_EN` and `TIMEOUT_CYC=16`.
  - Req drops after 16 cycles and `o_timeout_err`=1.
  - Remaining slots are serviced and `o_frame_done` still pulses.
- **Reset mid-frame**: `rst` asserted during REQ.
  - Next cycle: `o_obj_req=0`, `o_busy=0`, `o_overrun=0`, `o_round_cnt=0`.

Source files
------------

// File: rtl/frame_step_master_pkg.sv
// Shared types and constants for the per-frame object step scheduler.
package frame_step_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAL,
        ST_SETTLE,
        ST_SCAN,
        ST_REQ,
        ST_GAP,
        ST_DONE
    } fsm_state_t;

    localparam int OBJ_GADGET     = 0;
    localparam int OBJ_BALL       = 1;
    localparam int ROUND_CNT_BITS = 8;

    function automatic logic [ROUND_CNT_BITS-1:0] sat_inc(input logic [ROUND_CNT_BITS-1:0] v);
        return (&v) ? v : v + ROUND_CNT_BITS'(1);
    endfunction

endpackage

// File: rtl/frame_step_if.sv
// Step handshake bundle between the frame scheduler (master) and the object array (slave).
interface frame_step_if
    import frame_step_master_pkg::*;
#(
    parameter int N_OBJ = 4
) ();

    logic                      i_frame_start;
    logic [N_OBJ-1:0]          i_obj_en;
    logic                      o_cal_frame;
    logic [N_OBJ-1:0]          o_obj_req;
    logic [N_OBJ-1:0]          i_obj_ack;
    logic [N_OBJ-1:0]          i_obj_frame_term;
    logic                      o_busy;
    logic                      o_frame_done;
    logic [ROUND_CNT_BITS-1:0] o_round_cnt;
    logic                      o_overrun;
    logic                      o_timeout_err;

    modport master (
        input  i_frame_start, i_obj_en, i_obj_ack, i_obj_frame_term,
        output o_cal_frame, o_obj_req, o_busy, o_frame_done,
               o_round_cnt, o_overrun, o_timeout_err
    );

    modport slave (
        output i_frame_start, i_obj_en, i_obj_ack, i_obj_frame_term,
        input  o_cal_frame, o_obj_req, o_busy, o_frame_done,
               o_round_cnt, o_overrun, o_timeout_err
    );

endinterface

// File: rtl/frame_step_master_rr_slot_ptr.sv
// Round-robin slot pointer: clears to slot 0, advances with wrap, flags a completed round.
module rr_slot_ptr #(
    parameter int N_SLOT = 4,
    parameter int PTR_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [PTR_W-1:0] ptr,
    output logic             last,
    output logic             round_inc
);

    logic [PTR_W-1:0] ptr_reg, ptr_next;

    assign ptr       = ptr_reg;
    assign last      = (ptr_reg == PTR_W'(N_SLOT - 1));
    assign round_inc = advance && last && !clear;

    always_comb begin
        ptr_next = ptr_reg;
        if (clear) begin
            ptr_next = '0;
        end else if (advance) begin
            ptr_next = last ? '0 : ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/frame_step_master.sv
// Per-frame step scheduler: broadcasts cal_frame, then round-robins single-step grants
// until every enabled object reports frame_term. Optional ack watchdog: FSM_TIMEOUT_EN.
module frame_step_master
    import frame_step_master_pkg::*;
#(
    parameter int N_OBJ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst,
    frame_step_if.master bus
);

    localparam int PTR_W = $clog2(N_OBJ);

    if (N_OBJ < 2 || N_OBJ > 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("frame_step_master: unsupported N_OBJ or TIMEOUT_CYC");
    end

    fsm_state_t                state_reg, state_next;
    logic [N_OBJ-1:0]          en_q_reg, en_q_next;
    logic [ROUND_CNT_BITS-1:0] round_cnt_reg, round_cnt_next;
    logic                      timeout_err_reg, timeout_err_next;
    logic                      overrun_reg;
    logic                      cal_frame_reg, frame_done_reg, busy_reg;
    logic [N_OBJ-1:0]          req_reg, req_next;

    logic             ptr_clear, ptr_advance, ptr_last, round_inc;
    logic [PTR_W-1:0] ptr;
    logic             handshake, all_done, timeout_hit;

    rr_slot_ptr #(
        .N_SLOT (N_OBJ),
        .PTR_W  (PTR_W)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .clear     (ptr_clear),
        .advance   (ptr_advance),
        .ptr       (ptr),
        .last      (ptr_last),
        .round_inc (round_inc)
    );

    assign handshake = req_reg[ptr] && bus.i_obj_ack[ptr];
    assign all_done  = ((en_q_reg & ~bus.i_obj_frame_term) == '0);

`ifdef FSM_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
    logic [WD_W-1:0] wd_cnt_reg;

    // Counts cycles spent in the current REQ; restarts for every new grant.
    always_ff @(posedge clk) begin
        if (rst || state_reg != ST_REQ) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
        end
    end

    assign timeout_hit = (state_reg == ST_REQ) && (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next       = state_reg;
        en_q_next        = en_q_reg;
        timeout_err_next = timeout_err_reg;
        ptr_clear        = 1'b0;
        ptr_advance      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_frame_start) begin
                    state_next = ST_CAL;
                end
            end
            ST_CAL: begin
                en_q_next  = bus.i_obj_en;
                ptr_clear  = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (en_q_reg[ptr] && !bus.i_obj_frame_term[ptr]) begin
                    state_next = ST_REQ;
                end else begin
                    ptr_advance = 1'b1;
                    if (ptr_last && all_done) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (handshake) begin
                    state_next = ST_GAP;
                end else if (timeout_hit) begin
                    // A silent object is treated as terminated for the rest of this frame.
                    en_q_next[ptr]   = 1'b0;
                    timeout_err_next = 1'b1;
                    state_next       = ST_GAP;
                end
            end
            ST_GAP: begin
                ptr_advance = 1'b1;
                state_next  = (ptr_last && all_done) ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        round_cnt_next = round_cnt_reg;
        if (state_reg == ST_CAL) begin
            round_cnt_next = '0;
        end else if (round_inc) begin
            round_cnt_next = sat_inc(round_cnt_reg);
        end
    end

    // The pointer never moves on the SCAN->REQ transition, so the current slot is the grant target.
    for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_req
        assign req_next[gi] = (state_next == ST_REQ) && (ptr == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            en_q_reg        <= '0;
            round_cnt_reg   <= '0;
            timeout_err_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            cal_frame_reg   <= 1'b0;
            frame_done_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            req_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            en_q_reg        <= en_q_next;
            round_cnt_reg   <= round_cnt_next;
            timeout_err_reg <= timeout_err_next;
            if (bus.i_frame_start && state_reg != ST_IDLE) begin
                overrun_reg <= 1'b1;
            end
            cal_frame_reg   <= (state_next == ST_CAL);
            frame_done_reg  <= (state_next == ST_DONE);
            busy_reg        <= (state_next != ST_IDLE);
            req_reg         <= req_next;
        end
    end

    assign bus.o_cal_frame   = cal_frame_reg;
    assign bus.o_obj_req     = req_reg;
    assign bus.o_busy        = busy_reg;
    assign bus.o_frame_done  = frame_done_reg;
    assign bus.o_round_cnt   = round_cnt_reg;
    assign bus.o_overrun     = overrun_reg;
    assign bus.o_timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_frame_step_master.sv
// Randomized frame bench: responder objects with per-frame step counts and ack latency,
// compared against a round-robin schedule model computed from the scheduling rules.
module tb_frame_step_master;
    import frame_step_master_pkg::*;

    localparam int N   = 4;
    localparam int TOC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_step_if #(.N_OBJ(N)) bus ();

    frame_step_master #(.N_OBJ(N), .TIMEOUT_CYC(TOC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Responder objects
    int steps[N];
    int lat[N];
    bit mute[N];
    int done_cnt[N];
    int hold[N];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.o_cal_frame) begin
                done_cnt[i] <= 0;
                hold[i]     <= 0;
            end else if (bus.o_obj_req[i] && bus.i_obj_ack[i]) begin
                done_cnt[i] <= done_cnt[i] + 1;
                hold[i]     <= 0;
            end else if (bus.o_obj_req[i]) begin
                hold[i] <= hold[i] + 1;
            end else begin
                hold[i] <= 0;
            end
        end
    end

    always_comb begin
        bus.i_obj_ack        = '0;
        bus.i_obj_frame_term = '0;
        for (int i = 0; i < N; i++) begin
            bus.i_obj_ack[i]        = bus.o_obj_req[i] && !mute[i] && (hold[i] >= lat[i]);
            bus.i_obj_frame_term[i] = (done_cnt[i] >= steps[i]);
        end
    end

    // Monitor
    int         cyc = 0;
    int         hs_q[$];
    int         done_n, cal_n, done_cyc, start_cyc, req2_hi;
    bit         start_seen, multi_req;
    logic [N-1:0] req_seen;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++)
            if (bus.o_obj_req[i] && bus.i_obj_ack[i]) hs_q.push_back(i);
        if ($countones(bus.o_obj_req) > 1) multi_req = 1'b1;
        req_seen = req_seen | bus.o_obj_req;
        if (bus.o_obj_req[2]) req2_hi++;
        if (bus.i_frame_start && !start_seen) begin
            start_seen = 1'b1;
            start_cyc  = cyc;
        end
        if (bus.o_frame_done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (bus.o_cal_frame) cal_n++;
    end

    int ovr_exp = 0;
    int te_exp  = 0;

    // Reference schedule: whole rounds over all slots until no enabled object has steps left.
    task automatic model(input logic [N-1:0] en, output int exp_q[$], output int rounds,
                         output int cycles);
        int left[N];
        bit any;
        exp_q  = {};
        rounds = 0;
        cycles = 3;
        for (int i = 0; i < N; i++) left[i] = en[i] ? steps[i] : 0;
        do begin
            rounds++;
            for (int i = 0; i < N; i++) begin
                cycles += 1;
                if (left[i] > 0) begin
                    if (mute[i]) begin
                        cycles += TOC + 1;
                        left[i] = 0;
                    end else begin
                        exp_q.push_back(i);
                        left[i]--;
                        cycles += 2 + lat[i];
                    end
                end
            end
            any = 1'b0;
            for (int i = 0; i < N; i++) if (left[i] > 0) any = 1'b1;
        end while (any);
    endtask

    task automatic clear_monitor();
        hs_q       = {};
        done_n     = 0;
        cal_n      = 0;
        done_cyc   = 0;
        start_cyc  = 0;
        req2_hi    = 0;
        start_seen = 1'b0;
        multi_req  = 1'b0;
        req_seen   = '0;
    endtask

    task automatic run_frame(input string name, input logic [N-1:0] en, input int extra_at);
        int exp_q[$];
        int rounds, cycles, guard;
        model(en, exp_q, rounds, cycles);
        @(posedge clk); #1;
        clear_monitor();
        bus.i_obj_en      = en;
        bus.i_frame_start = 1'b1;
        @(posedge clk); #1;
        bus.i_frame_start = 1'b0;
        guard = 0;
        while (done_n == 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
            if (guard == extra_at) begin
                #1 bus.i_frame_start = 1'b1;
                ovr_exp = 1;
                @(posedge clk); #1;
                bus.i_frame_start = 1'b0;
                guard++;
            end
        end
        check_eq({name, "_done_seen"}, int'(done_n != 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq({name, "_done_once"}, done_n, 1);
        check_eq({name, "_cal_once"}, cal_n, 1);
        check_eq({name, "_done_latency"}, done_cyc - start_cyc, cycles);
        check_eq({name, "_round_cnt"}, int'(bus.o_round_cnt), rounds);
        check_eq({name, "_hs_count"}, hs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < hs_q.size(); k++)
            check_eq($sformatf("%s_order%0d", name, k), hs_q[k], exp_q[k]);
        check_eq({name, "_onehot"}, int'(multi_req), 0);
        check_eq({name, "_busy_after"}, int'(bus.o_busy), 0);
        check_eq({name, "_overrun"}, int'(bus.o_overrun), ovr_exp);
        check_eq({name, "_timeout_err"}, int'(bus.o_timeout_err), te_exp);
        $display("frame %s en=%b steps=%0d,%0d,%0d,%0d rounds=%0d handshakes=%0d latency=%0d",
                 name, en, steps[0], steps[1], steps[2], steps[3], bus.o_round_cnt,
                 hs_q.size(), done_cyc - start_cyc);
    endtask

    initial begin
        int guard;
        bus.i_frame_start = 1'b0;
        bus.i_obj_en      = '0;
        for (int i = 0; i < N; i++) begin
            steps[i] = 0;
            lat[i]   = 0;
            mute[i]  = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req", int'(bus.o_obj_req), 0);
        check_eq("rst_busy", int'(bus.o_busy), 0);
        check_eq("rst_round", int'(bus.o_round_cnt), 0);
        check_eq("rst_overrun", int'(bus.o_overrun), 0);
        check_eq("rst_timeout", int'(bus.o_timeout_err), 0);
        check_eq("rst_cal_done", int'({bus.o_cal_frame, bus.o_frame_done}), 0);
        rst = 1'b0;

        steps[0] = 3;
        run_frame("single", 4'b0001, -1);
        check_eq("single_req_hi_bits", int'(req_seen[3:1]), 0);

        steps[OBJ_GADGET] = 5;
        steps[OBJ_BALL]   = 2;
        run_frame("two_obj", 4'b0011, -1);
        check_eq("two_obj_rounds_const", int'(bus.o_round_cnt), 5);

        run_frame("all_off", 4'b0000, -1);
        check_eq("all_off_latency_const", done_cyc - start_cyc, 7);

        for (int f = 0; f < 24; f++) begin
            for (int i = 0; i < N; i++) begin
                steps[i] = $urandom_range(0, 5);
                lat[i]   = (f < 8) ? 0 : $urandom_range(0, 2);
            end
            run_frame($sformatf("rand%0d", f), N'($urandom), -1);
        end

        for (int i = 0; i < N; i++) begin
            steps[i] = 2;
            lat[i]   = 0;
        end
        run_frame("overrun", 4'b1111, 5);
        check_eq("overrun_no_second_cal", cal_n, 1);
        run_frame("overrun_sticky", 4'b0101, -1);

        // Reset in the middle of a REQ
        steps[0] = 3;
        lat[0]   = 2;
        @(posedge clk); #1;
        clear_monitor();
        bus.i_obj_en      = 4'b0001;
        bus.i_frame_start = 1'b1;
        @(posedge clk); #1;
        bus.i_frame_start = 1'b0;
        guard = 0;
        while (bus.o_obj_req == '0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("rstmid_req_seen", int'(bus.o_obj_req != '0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rstmid_req", int'(bus.o_obj_req), 0);
        check_eq("rstmid_busy", int'(bus.o_busy), 0);
        check_eq("rstmid_overrun", int'(bus.o_overrun), 0);
        check_eq("rstmid_round", int'(bus.o_round_cnt), 0);
        rst = 1'b0;
        ovr_exp = 0;
        te_exp  = 0;
        $display("frame rstmid reset applied during REQ");
        lat[0] = 0;
        run_frame("after_rst", 4'b0001, -1);

`ifdef FSM_TIMEOUT_EN
        steps[0] = 1;
        steps[1] = 1;
        steps[2] = 1;
        steps[3] = 0;
        for (int i = 0; i < N; i++) lat[i] = 0;
        mute[2] = 1'b1;
        te_exp  = 1;
        run_frame("watchdog", 4'b0111, -1);
        check_eq("watchdog_req2_cycles", req2_hi, TOC);
        mute[2] = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
